// File: rtl/fsa_col_edge_writer.sv
// Writer side of the ping-pong column blockram: per-column {val, top, bot} record
// of the first/last foreground row, built by a 3-stage read-modify-write pipeline.
module fsa_col_edge_writer #(
  parameter int C_IMG_WW        = 12,
  parameter int C_IMG_HW        = 12,
  parameter int C_CHANNEL_WIDTH = 8,
  parameter int BR_AW           = C_IMG_WW
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [C_IMG_HW-1:0]        height,
  input  logic [C_IMG_WW-1:0]        width,
  input  logic [C_CHANNEL_WIDTH-1:0] threshold,
  input  logic                       s_axis_tvalid,
  input  logic [C_CHANNEL_WIDTH-1:0] s_axis_tdata,
  input  logic                       s_axis_tuser,
  input  logic                       s_axis_tlast,
  output logic                       s_axis_tready,
  input  logic [C_IMG_WW-1:0]        s_axis_source_x,
  input  logic [C_IMG_HW-1:0]        s_axis_source_y,
  output logic                       mem_rd_en,
  output logic [BR_AW:0]             mem_rd_addr,
  input  logic [2*C_IMG_HW:0]        mem_rd_data,
  output logic                       mem_wr_en,
  output logic [BR_AW:0]             mem_wr_addr,
  output logic [2*C_IMG_HW:0]        mem_wr_data,
  output logic                       rd_bank,
  output logic                       frame_done
);
  localparam int RW = 1 + 2*C_IMG_HW;

  typedef enum logic [1:0] {IDLE, SCAN, FLUSH, COMMIT} state_t;

  state_t              state;
  logic                flush_cnt;
  logic                wr_bank;
  logic                acc, proc, is_last;
  logic [2:1]          vld_pipe;
  logic                fg_q, first_q, bank_q;
  logic [BR_AW-1:0]    x_q;
  logic [C_IMG_HW-1:0] y_q;
  logic [RW-1:0]       new_rec;
  logic                unused_tlast;

  assign unused_tlast  = s_axis_tlast;
  assign wr_bank       = ~rd_bank;
  assign s_axis_tready = (state == IDLE) || (state == SCAN);
  assign frame_done    = (state == COMMIT);
  assign acc           = s_axis_tvalid & s_axis_tready;
  // In IDLE only a start-of-frame pixel enters the pipeline.
  assign proc          = acc & ((state == SCAN) | s_axis_tuser);
  assign is_last       = (s_axis_source_x == width - 1'b1) && (s_axis_source_y == height - 1'b1);

  assign mem_rd_en   = proc;
  assign mem_rd_addr = {wr_bank, BR_AW'(s_axis_source_x)};
  assign mem_wr_en   = vld_pipe[2];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      flush_cnt <= 1'b0;
      rd_bank   <= 1'b0;
    end else begin
      flush_cnt <= 1'b0;
      case (state)
        IDLE:   if (proc) state <= is_last ? FLUSH : SCAN;
        SCAN:   if (proc && !s_axis_tuser && is_last) state <= FLUSH;
        FLUSH: begin
          flush_cnt <= 1'b1;
          if (flush_cnt) state <= COMMIT;
        end
        COMMIT: begin
          rd_bank <= ~rd_bank;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Row 0 (or a restart) ignores stale RAM content, so no clear pass is needed.
  always_comb begin
    new_rec = mem_rd_data;
    if (first_q)
      new_rec = fg_q ? {1'b1, y_q, y_q} : '0;
    else if (fg_q)
      new_rec = mem_rd_data[RW-1] ? {1'b1, mem_rd_data[2*C_IMG_HW-1:C_IMG_HW], y_q}
                                  : {1'b1, y_q, y_q};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_pipe    <= '0;
      fg_q        <= 1'b0;
      first_q     <= 1'b0;
      bank_q      <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
    end else begin
      vld_pipe <= {vld_pipe[1], proc};
      if (proc) begin
        fg_q    <= s_axis_tdata < threshold;
        first_q <= (s_axis_source_y == '0) | s_axis_tuser;
        bank_q  <= wr_bank;
        x_q     <= BR_AW'(s_axis_source_x);
        y_q     <= s_axis_source_y;
      end
      if (vld_pipe[1]) begin
        mem_wr_addr <= {bank_q, x_q};
        mem_wr_data <= new_rec;
      end
    end
  end
endmodule

// File: tb/tb_fsa_col_edge_writer.sv
// Scoreboard bench for fsa_col_edge_writer: driver pushes expected writes, monitor
// pops them on mem_wr_en; final column records checked against hand-computed values.
module tb_fsa_col_edge_writer;
  localparam int WW = 12, HW = 12, CW = 8, AW = 12, RW = 25;
  localparam int W = 4, H = 3;

  logic           clk, resetn;
  logic [HW-1:0]  height;
  logic [WW-1:0]  width;
  logic [CW-1:0]  threshold;
  logic           s_axis_tvalid, s_axis_tuser, s_axis_tlast, s_axis_tready;
  logic [CW-1:0]  s_axis_tdata;
  logic [WW-1:0]  s_axis_source_x;
  logic [HW-1:0]  s_axis_source_y;
  logic           mem_rd_en, mem_wr_en, rd_bank, frame_done;
  logic [AW:0]    mem_rd_addr, mem_wr_addr;
  logic [RW-1:0]  mem_rd_data, mem_wr_data;

  fsa_col_edge_writer #(.C_IMG_WW(WW), .C_IMG_HW(HW), .C_CHANNEL_WIDTH(CW), .BR_AW(AW)) dut (
    .clk(clk), .resetn(resetn), .height(height), .width(width), .threshold(threshold),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .s_axis_source_x(s_axis_source_x), .s_axis_source_y(s_axis_source_y),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .rd_bank(rd_bank), .frame_done(frame_done));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Blockram model; never-written words return garbage to prove row 0 ignores RAM content.
  logic [RW-1:0] ram   [0:8191];
  bit            wrote [0:8191];
  always @(posedge clk) begin
    if (mem_wr_en) begin
      ram[mem_wr_addr]   <= mem_wr_data;
      wrote[mem_wr_addr] <= 1'b1;
    end
    if (mem_rd_en) mem_rd_data <= wrote[mem_rd_addr] ? ram[mem_rd_addr] : 25'h1ABCDEF;
  end

  typedef struct {
    logic [AW:0]   addr;
    logic [RW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t          q[$];
  exp_t          mon_e;
  int            n_chk = 0, n_fail = 0;
  int            fd_cnt = 0, wr_cnt = 0;
  logic [RW-1:0] mrec [0:1][0:15];
  bit            in_frame = 1'b0;
  bit            mbank = 1'b1;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [RW-1:0] rec(input bit v, input int t, input int b);
    return {v, 12'(t), 12'(b)};
  endfunction

  always @(negedge clk) begin
    if (resetn) begin
      if (frame_done) fd_cnt++;
      if (mem_wr_en) begin
        wr_cnt++;
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_write: addr %0h data %0h with empty scoreboard", mem_wr_addr, mem_wr_data);
        end else begin
          mon_e = q.pop_front();
          chk("wr_addr", mem_wr_addr, mon_e.addr);
          chk("wr_data", mem_wr_data, mon_e.data);
          chk("wr_cycle", cyc, mon_e.cyc);
        end
      end
    end
  end

  task automatic send_pix(input int x, input int y, input logic [7:0] d, input bit tu, input int gap);
    int            guard;
    exp_t          e;
    bit            fg;
    logic [RW-1:0] old, nr;
    logic [11:0]   yy;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      s_axis_tvalid = 1'b0;
    end
    @(negedge clk);
    s_axis_tvalid = 1'b1; s_axis_tdata = d; s_axis_tuser = tu; s_axis_tlast = (x == W-1);
    s_axis_source_x = 12'(x); s_axis_source_y = 12'(y);
    guard = 0;
    while (!s_axis_tready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!s_axis_tready) begin
      chk("tready_wait", s_axis_tready, 1);
      return;
    end
    if (in_frame || tu) begin
      fg  = d < threshold;
      yy  = 12'(y);
      old = mrec[mbank][x];
      if (tu || y == 0)  nr = fg ? {1'b1, yy, yy} : '0;
      else if (!fg)      nr = old;
      else if (old[24])  nr = {1'b1, old[23:12], yy};
      else               nr = {1'b1, yy, yy};
      mrec[mbank][x] = nr;
      e.addr = {mbank, 12'(x)};
      e.data = nr;
      e.cyc  = cyc + 2;
      q.push_back(e);
      in_frame = 1'b1;
      if (x == W-1 && y == H-1) begin
        in_frame = 1'b0;
        mbank    = ~mbank;
      end
    end
  endtask

  task automatic send_row0(input logic [3:0] mask);
    for (int x = 0; x < W; x++) send_pix(x, 0, mask[x] ? 8'h20 : 8'hFF, x == 0, 0);
  endtask

  task automatic send_frame(input logic [11:0] mask, input logic [7:0] light, input bit gaps);
    int lowcnt;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        send_pix(x, y, mask[y*W+x] ? 8'h20 : light, (x == 0 && y == 0),
                 gaps ? int'($urandom_range(0, 1)) : 0);
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    lowcnt = 0;
    while (!s_axis_tready && lowcnt < 20) begin
      lowcnt++;
      @(negedge clk);
    end
    chk("tready_low_cycles", lowcnt, 3);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int fd0, wr0;
    resetn = 1'b0; height = 12'(H); width = 12'(W); threshold = 8'h80;
    s_axis_tvalid = 0; s_axis_tdata = 0; s_axis_tuser = 0; s_axis_tlast = 0;
    s_axis_source_x = 0; s_axis_source_y = 0;
    repeat (3) @(negedge clk);
    chk("rst_tready", s_axis_tready, 1);
    chk("rst_rd_bank", rd_bank, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_wr_en", mem_wr_en, 0);
    chk("rst_rd_en", mem_rd_en, 0);
    resetn = 1'b1;

    // Pixel without tuser while idle is dropped
    send_pix(2, 1, 8'h20, 0, 0);
    @(negedge clk);
    s_axis_tvalid = 1'b0;

    // Frame A: all light, bank 1
    fd0 = fd_cnt; wr0 = wr_cnt;
    send_frame(12'h000, 8'hFF, 0);
    chk("A_frame_done", fd_cnt - fd0, 1);
    chk("A_writes", wr_cnt - wr0, 12);
    chk("A_rd_bank", rd_bank, 1);
    for (int x = 0; x < W; x++) chk("A_col", ram[4096+x], 0);

    // Frame B: column 2 dark on rows 1..2, bank 0
    send_frame(12'h440, 8'hFF, 0);
    chk("B_rd_bank", rd_bank, 0);
    chk("B_col2", ram[2], rec(1, 1, 2));
    chk("B_col0", ram[0], 0);
    chk("B_col3", ram[3], 0);

    // Frame C: col0 dark at rows 0 and 2; light pixels equal threshold
    send_frame(12'h101, 8'h80, 0);
    chk("C_rd_bank", rd_bank, 1);
    chk("C_col0", ram[4096], rec(1, 0, 2));
    chk("C_col1", ram[4097], 0);

    // Frame D: random tvalid gaps, col1 dark rows 0..1
    send_frame(12'h022, 8'hFF, 1);
    chk("D_rd_bank", rd_bank, 0);
    chk("D_col1", ram[1], rec(1, 0, 1));

    // Frame E: row 0 then restart on tuser, full frame with col3 dark at row 2
    fd0 = fd_cnt;
    send_row0(4'b0010);
    send_frame(12'h800, 8'hFF, 0);
    chk("E_frame_done", fd_cnt - fd0, 1);
    chk("E_rd_bank", rd_bank, 1);
    chk("E_col1", ram[4097], 0);
    chk("E_col3", ram[4099], rec(1, 2, 2));

    // Reset mid-row, then full dark frame
    send_pix(0, 0, 8'h20, 1, 0);
    send_pix(1, 0, 8'h20, 0, 0);
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    #1 resetn = 1'b0;
    q.delete();
    in_frame = 1'b0;
    mbank = 1'b1;
    @(negedge clk);
    chk("R_wr_en", mem_wr_en, 0);
    chk("R_rd_bank", rd_bank, 0);
    chk("R_tready", s_axis_tready, 1);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    fd0 = fd_cnt;
    send_frame(12'hFFF, 8'hFF, 0);
    chk("F_frame_done", fd_cnt - fd0, 1);
    chk("F_rd_bank", rd_bank, 1);
    for (int x = 0; x < W; x++) chk("F_col", ram[4096+x], rec(1, 0, 2));

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
